// File: rtl/joy_db15_if.sv
// DB15 serial link pins between a host (master) and the responder (slave).
`timescale 1ns/1ps
interface joy_db15_if;
  logic joy_clk;   // host shift clock, asynchronous to the responder clock
  logic joy_load;  // host load strobe, active-low
  logic joy_data;  // serial data, active-low (0 = pressed)

  modport master (output joy_clk, output joy_load, input  joy_data);
  modport slave  (input  joy_clk, input  joy_load, output joy_data);
endinterface

// File: rtl/joy_db15_tx.sv
// joy_db15_tx: responder side of the DB15 serial joystick link.
// Samples two player words on the host load strobe and shifts them out
// one bit per host clock, active-low, joystick1[0] first.
// Optional build macro: JOY_DB15_TX_WATCHDOG_EN adds a stalled-host watchdog
// that raises link_idle and releases all buttons.
`timescale 1ns/1ps

// Synchronizer followed by a consecutive-sample stability filter.
module joy_db15_tx_sync_filt #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_CYCLES = 3,
  parameter logic        RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin,
  output logic lvl
);
  localparam int unsigned CW = 4;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   filt_q, filt_d;
  logic                   samp;

  assign samp = sync_q[SYNC_STAGES-1];
  assign lvl  = filt_q;

  // Shift the pin into the synchronizer; move the filtered level only after
  // FILT_CYCLES consecutive samples disagree with it.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pin};
    filt_d = filt_q;
    cnt_d  = '0;
    if (samp != filt_q) begin
      if (cnt_q == CW'(FILT_CYCLES - 1)) begin
        filt_d = samp;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Synchronizer and filter state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      cnt_q  <= '0;
      filt_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end
endmodule

module joy_db15_tx #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_CYCLES = 3,
  parameter int unsigned WD_CYCLES   = 2000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] joystick1,
  input  logic [15:0] joystick2,
  joy_db15_if.slave   link,
  output logic [5:0]  shift_count,
  output logic        frame_done,
  output logic        link_idle
);
  localparam int unsigned FRAME_BITS = 32;
  localparam int unsigned CNT_W      = 6;

  typedef enum logic {ST_LOAD, ST_SHIFT} state_e;

  state_e                state_q, state_d;
  logic [FRAME_BITS-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  frame_done_q, frame_done_d;
  logic                  joy_data_q, joy_data_d;
  logic                  clk_f_prev_q;
  logic                  clk_f, load_f, clk_rise;
  logic                  idle_force;

  joy_db15_tx_sync_filt #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_CYCLES (FILT_CYCLES),
    .RST_VAL     (1'b0)
  ) u_clk_filt (
    .clk     (clk),
    .reset_n (reset_n),
    .pin     (link.joy_clk),
    .lvl     (clk_f)
  );

  joy_db15_tx_sync_filt #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_CYCLES (FILT_CYCLES),
    .RST_VAL     (1'b1)
  ) u_load_filt (
    .clk     (clk),
    .reset_n (reset_n),
    .pin     (link.joy_load),
    .lvl     (load_f)
  );

  assign clk_rise = clk_f & ~clk_f_prev_q;

`ifdef JOY_DB15_TX_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(WD_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            link_idle_q, link_idle_d;
  logic            load_fall;

  assign load_fall  = (state_q == ST_SHIFT) & ~load_f;
  assign idle_force = link_idle_d;
  assign link_idle  = link_idle_q;

  // Count cycles since the last load; saturate and flag idle at WD_CYCLES.
  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (load_fall) begin
      wd_cnt_d = '0;
    end else if (wd_cnt_q != WD_W'(WD_CYCLES)) begin
      wd_cnt_d = wd_cnt_q + WD_W'(1);
    end
    link_idle_d = ~load_fall & (wd_cnt_d == WD_W'(WD_CYCLES));
  end

  // Watchdog state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt_q    <= '0;
      link_idle_q <= 1'b0;
    end else begin
      wd_cnt_q    <= wd_cnt_d;
      link_idle_q <= link_idle_d;
    end
  end
`else
  assign idle_force = 1'b0;
  assign link_idle  = 1'b0;
`endif

  // LOAD reloads the chain every cycle; SHIFT moves one bit per clk_f rise.
  // A load in the same cycle as a clock rise wins, and the rise is dropped.
  always_comb begin
    state_d      = load_f ? ST_SHIFT : ST_LOAD;
    sreg_d       = sreg_q;
    cnt_d        = cnt_q;
    frame_done_d = 1'b0;
    if (!load_f) begin
      sreg_d = ~{joystick2, joystick1};
      cnt_d  = '0;
    end else if ((state_q == ST_SHIFT) && clk_rise) begin
      sreg_d = {1'b1, sreg_q[FRAME_BITS-1:1]};
      if (cnt_q != CNT_W'(FRAME_BITS)) begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(FRAME_BITS - 1)) begin
          frame_done_d = 1'b1;
        end
      end
    end
    if (idle_force) begin
      sreg_d = '1;
    end
    joy_data_d = sreg_q[0];
  end

  // Frame state and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_SHIFT;
      sreg_q       <= '1;
      cnt_q        <= '0;
      frame_done_q <= 1'b0;
      joy_data_q   <= 1'b1;
      clk_f_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sreg_q       <= sreg_d;
      cnt_q        <= cnt_d;
      frame_done_q <= frame_done_d;
      joy_data_q   <= joy_data_d;
      clk_f_prev_q <= clk_f;
    end
  end

  assign link.joy_data = joy_data_q;
  assign shift_count   = cnt_q;
  assign frame_done    = frame_done_q;
endmodule
